seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter BLANK_CYCLES, default 16, giving the anti-ghost blanking length in clk cycles after each digit switch (0 = no blanking).
REQ-002 The block SHALL have port clk, input, 1 bit: the 100 MHz system clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port mux_clk, input, 1 bit: the scan-rate square wave from the clock divider, synchronous to clk.
REQ-005 The block SHALL have port digit_code, input, 20 bits: four 5-bit glyph codes, digit 0 in [4:0] through digit 3 in [19:15].
REQ-006 The block SHALL have port digit_en, input, 4 bits: per-digit enable; a 0 keeps that anode off.
REQ-007 The block SHALL have port dp_in, input, 4 bits: per-digit decimal point, 1 = lit.
REQ-008 The block SHALL have port an, output, 4 bits: active-low anodes, bit i = digit i.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low cathodes, [6:0] = g..a.
REQ-010 The block SHALL have port dp, output, 1 bit: active-low decimal-point cathode.
REQ-011 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new frame is latched.

Function
REQ-012 The block SHALL register mux_clk once (mux_q) and SHALL define tick = mux_clk & ~mux_q, i.e. one tick per mux_clk rising edge.
REQ-013 The block SHALL implement FSM states IDLE, BLANK and DRIVE.
REQ-014 The FSM SHALL stay in IDLE after reset until the first tick, holding an=4'b1111.
REQ-015 On a tick in any state, the block SHALL advance the digit index idx modulo 4, load blank_cnt with BLANK_CYCLES-1, and enter BLANK (or DRIVE directly when BLANK_CYCLES=0).
REQ-016 The first tick after reset SHALL select digit 0, not digit 1.
REQ-017 In BLANK, the block SHALL drive an=4'b1111, seg=7'h7F and dp=1, decrement blank_cnt each cycle, and enter DRIVE on the cycle after blank_cnt reaches 0.
REQ-018 In DRIVE, the block SHALL drive an[idx]=0 only when digit_en[idx]=1 (all other bits 1), seg = decode(latched code[idx]), and dp = ~latched dp[idx].
REQ-019 A tick arriving during BLANK SHALL advance idx and reload blank_cnt; blanking SHALL restart and no digit SHALL be skipped.
REQ-020 When idx moves to 0, the block SHALL capture digit_code, digit_en and dp_in into frame registers in that same clk edge and SHALL assert frame_start for exactly that following cycle.
REQ-021 The block SHALL ignore input changes mid-frame until the next capture, so a displayed frame never tears.
REQ-022 All of an, seg, dp and frame_start SHALL be registered outputs.
REQ-023 Timing SHALL be: tick in cycle N gives an=1111 during N+1..N+BLANK_CYCLES and the new digit lit from N+BLANK_CYCLES+1.
REQ-024 Glyph decode SHALL map codes 0-15 to hex 0-F, 16 to blank, 17 to 'H', 18 to 'L', 19 to 'P', and 20 to '-'; codes 21-31 SHALL decode to blank.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force an=4'b1111, seg=7'h7F, dp=1, frame_start=0, state=IDLE, idx=3 (so the first tick yields 0), mux_q=0, blank_cnt=0, frame codes=16 (blank), frame enables=0 and frame dp=0.
REQ-026 Reset mid-scan SHALL take effect without waiting for clk, and after release the block SHALL behave exactly as at power-up.

Structure
REQ-027 A shared package SHALL hold the glyph code constants (GLY_BLANK=16, GLY_H=17, GLY_L=18, GLY_P=19, GLY_DASH=20), the FSM state encoding, and the 7-bit segment patterns.
REQ-028 Glyph-to-segment decode SHALL be one combinational sub-module, seg_glyph_decoder (5-bit in, 7-bit active-low out), also reusable by other display paths.

Verification
REQ-029 With BLANK_CYCLES=16, digit_code={19,18,17,5}, digit_en=4'hF and four mux_clk rising edges, the bench SHALL observe an 1110, 1101, 1011, 0111 in turn with seg 0x12 ('5'), 0x09 ('H'), 0x47 ('L') and 0x0C ('P'), each preceded by exactly 16 cycles of an=1111.
REQ-030 With digit_en=4'b1010, the bench SHALL observe an=1111 throughout the digit 0 and digit 2 slots, while digits 1 and 3 light normally.
REQ-031 Changing digit_code while idx=2 SHALL leave digit 3 showing the old value; the new value SHALL appear only after the next frame_start pulse, which is exactly one cycle wide.
REQ-032 With BLANK_CYCLES=16 and a tick arriving 5 cycles into BLANK, idx SHALL advance by one and an SHALL stay 1111 for 16 further cycles.
REQ-033 Driving rst_n low mid-DRIVE between clk edges SHALL force an=1111 and seg=7F before the next clk edge; after release, the first tick SHALL light digit 0.
REQ-034 With BLANK_CYCLES=0, the new digit SHALL be lit in cycle N+1 after a tick in cycle N, and code 25 SHALL yield seg=7F.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph codes,
// scan FSM encoding and active-low segment patterns ([6:0] = g..a).
package seven_seg_scanner_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned GLYPH_W    = 5;

   localparam logic [GLYPH_W-1:0] GLY_BLANK = 5'd16;
   localparam logic [GLYPH_W-1:0] GLY_H     = 5'd17;
   localparam logic [GLYPH_W-1:0] GLY_L     = 5'd18;
   localparam logic [GLYPH_W-1:0] GLY_P     = 5'd19;
   localparam logic [GLYPH_W-1:0] GLY_DASH  = 5'd20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_A    = 7'h08;
   localparam logic [6:0] SEG_B    = 7'h03;
   localparam logic [6:0] SEG_C    = 7'h46;
   localparam logic [6:0] SEG_D    = 7'h21;
   localparam logic [6:0] SEG_E    = 7'h06;
   localparam logic [6:0] SEG_F    = 7'h0E;
   localparam logic [6:0] SEG_H    = 7'h09;
   localparam logic [6:0] SEG_L    = 7'h47;
   localparam logic [6:0] SEG_P    = 7'h0C;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seven_seg_scanner_glyph_decoder.sv
// Combinational glyph-code to active-low segment decoder; usable by any
// display path that shares the glyph code space.
module seg_glyph_decoder
   import seven_seg_scanner_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (code)
         5'd0:      seg = SEG_0;
         5'd1:      seg = SEG_1;
         5'd2:      seg = SEG_2;
         5'd3:      seg = SEG_3;
         5'd4:      seg = SEG_4;
         5'd5:      seg = SEG_5;
         5'd6:      seg = SEG_6;
         5'd7:      seg = SEG_7;
         5'd8:      seg = SEG_8;
         5'd9:      seg = SEG_9;
         5'd10:     seg = SEG_A;
         5'd11:     seg = SEG_B;
         5'd12:     seg = SEG_C;
         5'd13:     seg = SEG_D;
         5'd14:     seg = SEG_E;
         5'd15:     seg = SEG_F;
         GLY_BLANK: seg = SEG_OFF;
         GLY_H:     seg = SEG_H;
         GLY_L:     seg = SEG_L;
         GLY_P:     seg = SEG_P;
         GLY_DASH:  seg = SEG_DASH;
         default:   seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-switch anti-ghost
// blanking and frame-atomic capture of the displayed codes.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mux_clk,
   input  logic [19:0] digit_code,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);

   localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

   scan_state_e state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
   logic             mux_q;
   logic             tick;

   logic [3:0][4:0]  frame_code_q, frame_code_d;
   logic [3:0]       frame_en_q, frame_en_d;
   logic [3:0]       frame_dp_q, frame_dp_d;

   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_start_q, frame_start_d;

   logic [4:0]       glyph_code;
   logic [6:0]       glyph_seg;

   assign tick = mux_clk & ~mux_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= 2'd3;
         blank_cnt_q   <= '0;
         mux_q         <= 1'b0;
         frame_code_q  <= {NUM_DIGITS{GLY_BLANK}};
         frame_en_q    <= '0;
         frame_dp_q    <= '0;
         an_q          <= '1;
         seg_q         <= SEG_OFF;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         blank_cnt_q   <= blank_cnt_d;
         mux_q         <= mux_clk;
         frame_code_q  <= frame_code_d;
         frame_en_q    <= frame_en_d;
         frame_dp_q    <= frame_dp_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
      end
   end

   // A tick always wins over blank countdown, so a tick during BLANK restarts it.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      blank_cnt_d   = blank_cnt_q;
      frame_code_d  = frame_code_q;
      frame_en_d    = frame_en_q;
      frame_dp_d    = frame_dp_q;
      frame_start_d = 1'b0;
      if (tick) begin
         idx_d       = idx_q + 2'd1;
         blank_cnt_d = CNT_LOAD;
         state_d     = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
         if (idx_q == 2'd3) begin
            frame_code_d  = digit_code;
            frame_en_d    = digit_en;
            frame_dp_d    = dp_in;
            frame_start_d = 1'b1;
         end
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (blank_cnt_q == '0) begin
                  state_d = ST_DRIVE;
               end else begin
                  blank_cnt_d = blank_cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from next-state values so the registered pins line
   // up with the state they belong to, without an extra cycle of lag.
   assign glyph_code = frame_code_d[idx_d];

   seg_glyph_decoder u_glyph_decoder (
      .code (glyph_code),
      .seg  (glyph_seg)
   );

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == ST_DRIVE) begin
         an_d[idx_d] = ~frame_en_d[idx_d];
         seg_d       = glyph_seg;
         dp_d        = ~frame_dp_d[idx_d];
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (blanking of 16 and of 0).
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mux_clk;
   logic [19:0] digit_code;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;

   logic [3:0]  an_a, an_z;
   logic [6:0]  seg_a, seg_z;
   logic        dp_a, dp_z;
   logic        fs_a, fs_z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.BLANK_CYCLES(16)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .mux_clk     (mux_clk),
      .digit_code  (digit_code),
      .digit_en    (digit_en),
      .dp_in       (dp_in),
      .an          (an_a),
      .seg         (seg_a),
      .dp          (dp_a),
      .frame_start (fs_a)
   );

   seven_seg_scanner #(.BLANK_CYCLES(0)) dut_z (
      .clk         (clk),
      .rst_n       (rst_n),
      .mux_clk     (mux_clk),
      .digit_code  (digit_code),
      .digit_en    (digit_en),
      .dp_in       (dp_in),
      .an          (an_z),
      .seg         (seg_z),
      .dp          (dp_z),
      .frame_start (fs_z)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mux_clk high for one cycle; returns in the first cycle after the tick
   task automatic pulse_tick();
      mux_clk = 1'b1;
      step();
      mux_clk = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; mux_clk = 1'b0; digit_code = '0; digit_en = '0; dp_in = '0;
      #1 rst_n = 1'b0;
      step();
      checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL reset_an actual=%b expected=1111", an_a); end
      checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%h expected=7f", seg_a); end
      checks++; if (dp_a !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b expected=1", dp_a); end
      checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_frame_start actual=%b expected=0", fs_a); end
      checks++; if (an_z !== 4'hF) begin errors++; $display("FAIL reset_an_zero actual=%b expected=1111", an_z); end
      rst_n = 1'b1;
      repeat (5) step();
      checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL idle_an actual=%b expected=1111", an_a); end
      checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL idle_seg actual=%h expected=7f", seg_a); end
   endtask

   task automatic test_scan();
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      logic       exp_dp [4];
      logic       exp_fs;
      int         n;
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'h12, 7'h09, 7'h47, 7'h0C};
      exp_dp  = '{1'b0, 1'b1, 1'b0, 1'b1};
      digit_code = {5'd19, 5'd18, 5'd17, 5'd5};
      digit_en   = 4'hF;
      dp_in      = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         pulse_tick();
         exp_fs = (k == 0);
         checks++; if (fs_a !== exp_fs) begin errors++; $display("FAIL scan_frame_start[%0d] actual=%b expected=%b", k, fs_a, exp_fs); end
         n = 0;
         while (an_a === 4'hF && n < 40) begin
            n++;
            step();
         end
         checks++; if (n != 16) begin errors++; $display("FAIL scan_blank_len[%0d] actual=%0d expected=16", k, n); end
         checks++; if (an_a !== exp_an[k]) begin errors++; $display("FAIL scan_an[%0d] actual=%b expected=%b", k, an_a, exp_an[k]); end
         checks++; if (seg_a !== exp_seg[k]) begin errors++; $display("FAIL scan_seg[%0d] actual=%h expected=%h", k, seg_a, exp_seg[k]); end
         checks++; if (dp_a !== exp_dp[k]) begin errors++; $display("FAIL scan_dp[%0d] actual=%b expected=%b", k, dp_a, exp_dp[k]); end
         repeat (4) step();
      end
   endtask

   task automatic test_enable();
      logic [3:0] exp_an [4];
      exp_an   = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
      digit_en = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         pulse_tick();
         checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL enable_blank[%0d] actual=%b expected=1111", k, an_a); end
         repeat (16) step();
         checks++; if (an_a !== exp_an[k]) begin errors++; $display("FAIL enable_first[%0d] actual=%b expected=%b", k, an_a, exp_an[k]); end
         repeat (3) step();
         checks++; if (an_a !== exp_an[k]) begin errors++; $display("FAIL enable_later[%0d] actual=%b expected=%b", k, an_a, exp_an[k]); end
      end
   endtask

   task automatic test_no_tear();
      digit_en   = 4'hF;
      digit_code = {5'd3, 5'd2, 5'd1, 5'd0};
      pulse_tick(); repeat (16) step();
      checks++; if (seg_a !== 7'h40) begin errors++; $display("FAIL tear_d0_old actual=%h expected=40", seg_a); end
      pulse_tick(); repeat (16) step();
      checks++; if (seg_a !== 7'h79) begin errors++; $display("FAIL tear_d1_old actual=%h expected=79", seg_a); end
      pulse_tick(); repeat (16) step();
      digit_code = {5'd7, 5'd6, 5'd5, 5'd4};
      step();
      checks++; if (seg_a !== 7'h24) begin errors++; $display("FAIL tear_d2_old actual=%h expected=24", seg_a); end
      pulse_tick();
      checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL tear_no_frame_start actual=%b expected=0", fs_a); end
      repeat (16) step();
      checks++; if (an_a !== 4'b0111) begin errors++; $display("FAIL tear_d3_an actual=%b expected=0111", an_a); end
      checks++; if (seg_a !== 7'h30) begin errors++; $display("FAIL tear_d3_old actual=%h expected=30", seg_a); end
      pulse_tick();
      checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL tear_frame_start actual=%b expected=1", fs_a); end
      step();
      checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL tear_frame_start_width actual=%b expected=0", fs_a); end
      repeat (15) step();
      checks++; if (an_a !== 4'b1110) begin errors++; $display("FAIL tear_d0_new_an actual=%b expected=1110", an_a); end
      checks++; if (seg_a !== 7'h19) begin errors++; $display("FAIL tear_d0_new actual=%h expected=19", seg_a); end
      pulse_tick(); repeat (16) step();
      checks++; if (seg_a !== 7'h12) begin errors++; $display("FAIL tear_d1_new actual=%h expected=12", seg_a); end
   endtask

   task automatic test_blank_restart();
      int n;
      pulse_tick();
      repeat (4) step();
      checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL restart_mid_blank actual=%b expected=1111", an_a); end
      mux_clk = 1'b1;
      step();
      mux_clk = 1'b0;
      n = 0;
      while (an_a === 4'hF && n < 40) begin
         n++;
         step();
      end
      checks++; if (n != 16) begin errors++; $display("FAIL restart_blank_len actual=%0d expected=16", n); end
      checks++; if (an_a !== 4'b0111) begin errors++; $display("FAIL restart_an actual=%b expected=0111", an_a); end
      checks++; if (seg_a !== 7'h78) begin errors++; $display("FAIL restart_seg actual=%h expected=78", seg_a); end
   endtask

   task automatic test_async_reset();
      step();
      checks++; if (an_a !== 4'b0111) begin errors++; $display("FAIL areset_pre_an actual=%b expected=0111", an_a); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL areset_an actual=%b expected=1111", an_a); end
      checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL areset_seg actual=%h expected=7f", seg_a); end
      checks++; if (dp_a !== 1'b1) begin errors++; $display("FAIL areset_dp actual=%b expected=1", dp_a); end
      step(); step();
      rst_n = 1'b1;
      step();
      checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL areset_idle_an actual=%b expected=1111", an_a); end
      pulse_tick();
      checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL areset_frame_start actual=%b expected=1", fs_a); end
      repeat (16) step();
      checks++; if (an_a !== 4'b1110) begin errors++; $display("FAIL areset_first_an actual=%b expected=1110", an_a); end
      checks++; if (seg_a !== 7'h19) begin errors++; $display("FAIL areset_first_seg actual=%h expected=19", seg_a); end
   endtask

   task automatic test_zero_blank();
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      logic       exp_dp [4];
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'h08, 7'h7F, 7'h3F, 7'h7F};
      exp_dp  = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      digit_code = {5'd25, 5'd20, 5'd16, 5'd10};
      digit_en   = 4'hF;
      dp_in      = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         pulse_tick();
         if (k == 0) begin
            checks++; if (fs_z !== 1'b1) begin errors++; $display("FAIL zero_frame_start actual=%b expected=1", fs_z); end
            checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL zero_ref_blank actual=%b expected=1111", an_a); end
         end
         checks++; if (an_z !== exp_an[k]) begin errors++; $display("FAIL zero_an[%0d] actual=%b expected=%b", k, an_z, exp_an[k]); end
         checks++; if (seg_z !== exp_seg[k]) begin errors++; $display("FAIL zero_seg[%0d] actual=%h expected=%h", k, seg_z, exp_seg[k]); end
         checks++; if (dp_z !== exp_dp[k]) begin errors++; $display("FAIL zero_dp[%0d] actual=%b expected=%b", k, dp_z, exp_dp[k]); end
         repeat (3) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_scan();
      test_enable();
      test_no_tear();
      test_blank_restart();
      test_async_reset();
      test_zero_blank();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
